umem_arbiter: RTL
=================

Name: umem_arbiter

Overview:
- Shares one single-port unified word memory between three requesters: instruction fetch (IF), data access (MEM-stage LW/SW/LWCAB) and the debug/loader port (fills and dumps memory around a run).
- Arbitrates one access per cycle and tracks which requester owns each in-flight read.
- Returns read data after a fixed latency and drives pipeline stall requests for IF and MEM.
- Sits between the pipelined CPU core and the memory macro.

Parameters:
- ADDR_W, 32, byte-address width on requester ports
- MEM_AW, 10, memory word-address width (1024 words)
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4
- MAX_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win

Ports:
- clock, in, 1, rising-edge clock
- reset, in, 1, synchronous active-high reset
- dbg_req, in, 1, debug access request
- dbg_we, in, 1, debug write enable
- dbg_addr, in, ADDR_W, debug byte address
- dbg_wdata, in, 32, debug write data
- dbg_gnt, out, 1, debug request accepted this cycle
- dbg_rvalid, out, 1, debug read data valid
- d_req, in, 1, data request
- d_we, in, 1, data write enable (SW)
- d_addr, in, ADDR_W, data byte address
- d_wdata, in, 32, data write data
- d_gnt, out, 1, data request accepted
- d_rvalid, out, 1, data read valid
- f_req, in, 1, fetch request
- f_addr, in, ADDR_W, fetch byte address (PC)
- f_gnt, out, 1, fetch accepted
- f_rvalid, out, 1, fetch data valid
- rdata, out, 32, read data shared by all requesters; qualified by the per-requester rvalid
- stall_if, out, 1, f_req & ~f_gnt
- stall_mem, out, 1, d_req & ~d_gnt
- mem_en, out, 1, memory access enable
- mem_we, out, 1, memory write enable
- mem_addr, out, MEM_AW, memory word address = addr[MEM_AW+1:2]
- mem_wdata, out, 32, memory write data
- mem_rdata, in, 32, valid MEM_LAT cycles after a read issue

Behaviour:
- Grants are combinational in the request cycle; at most one gnt per cycle. mem_* mirror the granted request in the same cycle.
- Priority is dbg > d > f. Exception: when wait_cnt == MAX_WAIT and f_req=1, fetch wins over d (dbg still wins).
- wait_cnt: 2-bit-min counter (width clog2(MAX_WAIT+1)).
  - Increments when f_req & ~f_gnt; saturates at MAX_WAIT.
  - Clears on f_gnt or when f_req=0.
- Address bits [1:0] are ignored; no misalignment error is raised.
- Read tracking: shift register of MEM_LAT stages, each holding {valid, owner[1:0]}.
  - Stage 0 is loaded on a granted read (mem_we=0); writes load valid=0.
  - At the last stage, rvalid is asserted for the recorded owner and rdata = mem_rdata.
- Writes produce no rvalid. A write and a later read to the same address issue in order; memory semantics give the read the new value.
- Back-to-back reads from any mix of owners are fully pipelined, one per cycle; rvalids return in issue order.
- Requesters must hold req/addr/wdata stable until gnt. Dropping req before gnt is legal and cancels the request.
- Reset:
  - Clears wait_cnt and all tracking stages.
  - All rvalid=0 in the cycle after reset; gnt outputs are forced to 0 while reset=1.
  - Reads in flight at reset are discarded; no rvalid is produced for them.
- When no request is present: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Decomposition:
- Shared package cpu_pkg:
  - owner encoding OWN_F=0, OWN_D=1, OWN_DBG=2
  - opcode constants LW, SW, LWCAB, used by the core's d_req generation
- One sub-module, rd_tag_pipe: the MEM_LAT-deep {valid, owner} shift register with rvalid decode.
- Arbitration and wait_cnt live in the top.

Test Plan:
- Fetch only: f_req=1 with f_addr=0,4,8 on successive cycles → f_gnt=1 each cycle, mem_addr=0,1,2. With MEM_LAT=1, f_rvalid on the next cycles with rdata=IMEM words 0,1,2.
- Conflict: d_req (LW, addr 0x40) and f_req together → d_gnt=1, f_gnt=0, stall_if=1, mem_addr=16. Next cycle (d_req low) f_gnt=1.
- Starvation: d_req held high for 6 cycles plus f_req, MAX_WAIT=3 → f_gnt on cycle 4 and stall_mem=1 that cycle, then d_gnt resumes with wait_cnt=0.
- Debug preload: dbg writes 0xDEADBEEF to 0x8 while d_req and f_req are active → dbg_gnt=1, mem_we=1, mem_addr=2, no rvalid. A subsequent d read of 0x8 returns 0xDEADBEEF with d_rvalid.
- Pipelined mixed reads, MEM_LAT=3: reads issued dbg, d, f on consecutive cycles → dbg_rvalid, d_rvalid, f_rvalid on cycles 3, 4, 5 respectively, each with the matching word.
- Reset mid-flight: issue an f read, then assert reset the next cycle → no f_rvalid ever appears for it; all gnt=0 during reset; normal grants resume the cycle after reset drops.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: requester owner tags and the MEM-stage memory opcodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        OWN_F   = 2'd0,
        OWN_D   = 2'd1,
        OWN_DBG = 2'd2
    } owner_e;

    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2b;
    localparam logic [5:0] LWCAB = 6'h3a;

    // Used by the core to decide when a MEM-stage instruction raises d_req / d_we.
    function automatic logic is_mem_read(input logic [5:0] op);
        return (op == LW) || (op == LWCAB);
    endfunction

    function automatic logic is_mem_write(input logic [5:0] op);
        return op == SW;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks in-flight reads as {valid, owner} through LAT stages and decodes per-owner rvalid.
// Latency: rvalid LAT cycles after issue. No backpressure: one issue per cycle always accepted.
// Reads in flight when reset rises are dropped; outputs are held low while reset is high.
module rd_tag_pipe
    import cpu_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue_vld,
    input  logic [1:0] issue_own,
    output logic       f_rvalid,
    output logic       d_rvalid,
    output logic       dbg_rvalid
);

    logic [LAT-1:0]      vld_q;
    logic [LAT-1:0][1:0] own_q;
    logic                out_vld;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q[0] <= issue_vld;
            own_q[0] <= issue_own;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    // Masking with reset covers LAT=1, where a read issued just before reset sits in the last stage.
    assign out_vld    = vld_q[LAT-1] && !reset;
    assign f_rvalid   = out_vld && (own_q[LAT-1] == OWN_F);
    assign d_rvalid   = out_vld && (own_q[LAT-1] == OWN_D);
    assign dbg_rvalid = out_vld && (own_q[LAT-1] == OWN_DBG);

endmodule

// File: rtl/umem_arbiter.sv
// Arbitrates one single-port word memory between debug, data and fetch requesters (dbg > d > f).
// Latency: grant and mem_* in the request cycle; read data and rvalid MEM_LAT cycles later.
// Backpressure: a denied requester sees gnt=0 / stall_* and holds its request; fetch is forced after MAX_WAIT denials.
module umem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MEM_AW   = 10,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int              WC_W     = ($clog2(MAX_WAIT + 1) > 2) ? $clog2(MAX_WAIT + 1) : 2;
    localparam logic [WC_W-1:0] WAIT_SAT = WC_W'(MAX_WAIT);

    logic [WC_W-1:0]   wait_cnt;
    logic              f_force;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        issue_own;
    logic              issue_rd_vld;
    logic              unused_addr_bits;

    // A starved fetch overtakes data access but never debug.
    assign f_force   = f_req && (wait_cnt == WAIT_SAT);
    assign dbg_gnt   = !reset && dbg_req;
    assign d_gnt     = !reset && !dbg_req && d_req && !f_force;
    assign f_gnt     = !reset && !dbg_req && f_req && (!d_req || f_force);
    assign stall_if  = f_req && !f_gnt;
    assign stall_mem = d_req && !d_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        sel_addr  = '0;
        mem_wdata = '0;
        issue_own = OWN_F;
        if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            sel_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            issue_own = OWN_DBG;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            sel_addr  = d_addr;
            mem_wdata = d_wdata;
            issue_own = OWN_D;
        end else if (f_gnt) begin
            mem_en    = 1'b1;
            sel_addr  = f_addr;
        end
    end

    // Byte offset and bits above the memory size are dropped without any error.
    assign mem_addr         = sel_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{sel_addr[ADDR_W-1:MEM_AW+2], sel_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset || !f_req || f_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign issue_rd_vld = mem_en && !mem_we;
    assign rdata        = mem_rdata;

    rd_tag_pipe #(
        .LAT(MEM_LAT)
    ) u_rd_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .issue_vld  (issue_rd_vld),
        .issue_own  (issue_own),
        .f_rvalid   (f_rvalid),
        .d_rvalid   (d_rvalid),
        .dbg_rvalid (dbg_rvalid)
    );

endmodule
